// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//   Self-synchronising PRBS checker for a Fibonacci LFSR stream.
//   The receiver fills a local copy of the transmitter register from the
//   incoming bits, verifies LOCK_CNT consecutive predictions, then flywheels
//   on its own prediction.  Errors are counted while locked.  Too many errors
//   inside one observation window drop it back to FILL.
//
// Parameters
//   LENGTH   : LFSR register width in bits
//   TAPS     : feedback tap mask (bit i set -> register bit i feeds the XOR)
//   LOCK_CNT : consecutive matches needed to declare lock
//   WINDOW   : loss-of-lock observation window, in valid bits
//   LOSS_THR : errors inside one window that force loss of lock
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   din       : received serial PRBS bit
//   din_valid : qualifies din; nothing advances while low
//   clr       : synchronous clear of err_count and bit_count only
//   locked    : high while in LOCKED (registered)
//   err_pulse : one-cycle pulse per mismatched bit while LOCKED
//   err_count : saturating error count (LOCKED only)
//   bit_count : saturating count of bits checked while LOCKED
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int                LENGTH   = 16,
  parameter logic [LENGTH-1:0] TAPS     = LENGTH'(32'd53256),
  parameter int                LOCK_CNT = 32,
  parameter int                WINDOW   = 64,
  parameter int                LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [31:0] bit_count
);

  localparam int FILL_W  = $clog2(LENGTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  // "Last" values: reaching these on a qualifying bit completes the phase.
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LENGTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THR - 1);
  localparam logic [31:0]        CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_r;
  logic [LENGTH-1:0]   lfsr_r;
  logic [FILL_W-1:0]   fill_cnt_r;
  logic [MATCH_W-1:0]  match_cnt_r;
  logic [WIN_W-1:0]    win_cnt_r;
  logic [WERR_W-1:0]   win_err_r;
  logic                locked_r;
  logic                err_pulse_r;
  logic [31:0]         err_count_r;
  logic [31:0]         bit_count_r;

  logic                predicted_s;
  logic                mismatch_s;

  // Next transmitter bit: parity of the tapped register bits.
  function automatic logic predict_bit(input logic [LENGTH-1:0] bits);
    predict_bit = ^(bits & TAPS);
  endfunction

  // Saturating increment so the statistics never wrap.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    sat_inc = (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

  // Prediction for the current bit and its comparison with the received bit.
  always_comb begin
    predicted_s = predict_bit(lfsr_r);
    mismatch_s  = din ^ predicted_s;
  end

  // Acquisition / tracking state machine with its registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_FILL;
      lfsr_r      <= '0;
      fill_cnt_r  <= '0;
      match_cnt_r <= '0;
      win_cnt_r   <= '0;
      win_err_r   <= '0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= 1'b0;
      if (din_valid) begin
        case (state_r)
          ST_FILL: begin
            lfsr_r <= {lfsr_r[LENGTH-2:0], din};
            if (fill_cnt_r == FILL_LAST) begin
              fill_cnt_r <= '0;
              state_r    <= ST_VERIFY;
            end else begin
              fill_cnt_r <= fill_cnt_r + FILL_W'(1);
            end
          end
          ST_VERIFY: begin
            lfsr_r <= {lfsr_r[LENGTH-2:0], din};
            // An all-zero register predicts zeros forever; never trust it.
            if (lfsr_r == '0 || mismatch_s) begin
              match_cnt_r <= '0;
            end else if (match_cnt_r == MATCH_LAST) begin
              match_cnt_r <= '0;
              win_cnt_r   <= '0;
              win_err_r   <= '0;
              state_r     <= ST_LOCKED;
              locked_r    <= 1'b1;
            end else begin
              match_cnt_r <= match_cnt_r + MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            // Flywheel on our own prediction so line errors stay isolated.
            lfsr_r      <= {lfsr_r[LENGTH-2:0], predicted_s};
            err_pulse_r <= mismatch_s;
            // Loss is judged first so an error on a window's last bit counts
            // toward that window before the restart.
            if (mismatch_s && win_err_r == WERR_LAST) begin
              state_r     <= ST_FILL;
              locked_r    <= 1'b0;
              fill_cnt_r  <= '0;
              match_cnt_r <= '0;
              win_cnt_r   <= '0;
              win_err_r   <= '0;
            end else if (win_cnt_r == WIN_LAST) begin
              win_cnt_r <= '0;
              win_err_r <= '0;
            end else begin
              win_cnt_r <= win_cnt_r + WIN_W'(1);
              win_err_r <= win_err_r + WERR_W'(mismatch_s);
            end
          end
          default: begin
            state_r     <= ST_FILL;
            locked_r    <= 1'b0;
            fill_cnt_r  <= '0;
            match_cnt_r <= '0;
            win_cnt_r   <= '0;
            win_err_r   <= '0;
          end
        endcase
      end
    end
  end

  // Error and bit statistics; clr wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_r <= 32'd0;
      bit_count_r <= 32'd0;
    end else if (clr) begin
      err_count_r <= 32'd0;
      bit_count_r <= 32'd0;
    end else if (din_valid && state_r == ST_LOCKED) begin
      bit_count_r <= sat_inc(bit_count_r);
      if (mismatch_s) begin
        err_count_r <= sat_inc(err_count_r);
      end
    end
  end

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;
  assign bit_count = bit_count_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//   Scenario bench for lfsr_checker.  Each stimulus bit pushes the expected
//   {locked, err_pulse} after its edge onto a queue; the observed pair is
//   queued after the edge and each scenario pops and compares both queues.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam logic [15:0] TX_TAPS = 16'd53256;

  logic        clk;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  int n_checks;
  int n_pass;

  logic [15:0] tx_s;
  logic [1:0]  exp_q[$];
  logic [1:0]  obs_q[$];

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Fibonacci transmitter: emit fb and shift it in at the bottom.
  task automatic tx_bit(output logic b);
    logic fb;
    fb   = ^(tx_s & TX_TAPS);
    tx_s = {tx_s[14:0], fb};
    b    = fb;
  endtask

  // One clock of stimulus, queueing the expectation and the observation.
  task automatic step(input logic d, input logic v, input logic c,
                      input logic exp_lock, input logic exp_pulse);
    din       = d;
    din_valid = v;
    clr       = c;
    exp_q.push_back({exp_lock, exp_pulse});
    @(posedge clk);
    #1;
    obs_q.push_back({locked, err_pulse});
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    tx_s      = 16'd1;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b want 0", err_pulse); else n_pass++;
    n_checks++; if (err_count !== 32'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd0) $display("FAIL reset_bit_count: got %0d want 0", bit_count); else n_pass++;
  endtask

  task automatic test_lock();
    logic b;
    logic [1:0] e, o;
    int idx;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (i >= 48), 1'b0);
    end
    idx = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL lock_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (err_count !== 32'd0) $display("FAIL lock_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd52) $display("FAIL lock_bit_count: got %0d want 52", bit_count); else n_pass++;
  endtask

  // Continues from the locked state left by test_lock.
  task automatic test_single_error();
    logic b;
    logic [1:0] e, o;
    int idx;
    tx_bit(b);
    step(~b, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL single_err_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (err_count !== 32'd1) $display("FAIL single_err_count: got %0d want 1", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd83) $display("FAIL single_bit_count: got %0d want 83", bit_count); else n_pass++;
  endtask

  task automatic test_loss_of_lock();
    logic b, inv;
    logic [1:0] e, o;
    int idx;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (i >= 48), 1'b0);
    end
    // Eight errors at locked bits 10,12,...,24; lock falls on the 8th.
    for (int j = 0; j <= 24; j++) begin
      tx_bit(b);
      inv = (j >= 10) && (j % 2 == 0);
      step(b ^ inv, 1'b1, 1'b0, (j < 24), inv);
    end
    for (int k = 1; k <= 53; k++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (k >= 48), 1'b0);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL loss_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (err_count !== 32'd8) $display("FAIL loss_err_count: got %0d want 8", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd30) $display("FAIL loss_bit_count: got %0d want 30", bit_count); else n_pass++;
  endtask

  task automatic test_two_windows();
    logic b, inv;
    logic [1:0] e, o;
    int idx;
    do_reset();
    for (int i = 1; i <= 48; i++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (i >= 48), 1'b0);
    end
    // Seven errors ending on the last bit of window 0, seven opening window 1.
    for (int j = 0; j <= 140; j++) begin
      tx_bit(b);
      inv = (j >= 57) && (j <= 70);
      step(b ^ inv, 1'b1, 1'b0, 1'b1, inv);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL window_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (err_count !== 32'd14) $display("FAIL window_err_count: got %0d want 14", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd141) $display("FAIL window_bit_count: got %0d want 141", bit_count); else n_pass++;
  endtask

  task automatic test_zero_stream();
    logic [1:0] e, o;
    int idx;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL zero_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (bit_count !== 32'd0) $display("FAIL zero_bit_count: got %0d want 0", bit_count); else n_pass++;
  endtask

  task automatic test_valid_gaps();
    logic b, inv;
    logic [1:0] e, o;
    int vcount, idx;
    do_reset();
    vcount = 0;
    while (vcount < 60) begin
      if ($urandom_range(0, 2) == 0 || vcount == 55) begin
        // Idle cycle: random data must be ignored, err_pulse held low.
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, (vcount >= 48), 1'b0);
      end
      vcount++;
      tx_bit(b);
      inv = (vcount == 55);
      step(b ^ inv, 1'b1, 1'b0, (vcount >= 48), inv);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL gaps_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
    n_checks++; if (err_count !== 32'd1) $display("FAIL gaps_err_count: got %0d want 1", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd12) $display("FAIL gaps_bit_count: got %0d want 12", bit_count); else n_pass++;
  endtask

  task automatic test_reset_and_clr();
    logic b;
    logic [1:0] e, o;
    int idx;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (i >= 48), 1'b0);
    end
    // Asynchronous reset between clock edges while locked.
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (locked !== 1'b0) $display("FAIL midreset_locked: got %b want 0", locked); else n_pass++;
    n_checks++; if (err_pulse !== 1'b0) $display("FAIL midreset_err_pulse: got %b want 0", err_pulse); else n_pass++;
    n_checks++; if (err_count !== 32'd0) $display("FAIL midreset_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd0) $display("FAIL midreset_bit_count: got %0d want 0", bit_count); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, (k >= 48), 1'b0);
    end
    // Error and clr on the same edge: the clear wins.
    tx_bit(b);
    step(~b, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (err_count !== 32'd0) $display("FAIL clr_err_count: got %0d want 0", err_count); else n_pass++;
    n_checks++; if (bit_count !== 32'd0) $display("FAIL clr_bit_count: got %0d want 0", bit_count); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tx_bit(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    n_checks++; if (bit_count !== 32'd3) $display("FAIL post_clr_bit_count: got %0d want 3", bit_count); else n_pass++;
    n_checks++; if (err_count !== 32'd0) $display("FAIL post_clr_err_count: got %0d want 0", err_count); else n_pass++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reset_clr_seq[%0d]: {locked,err_pulse} got %b want %b", idx, o, e); else n_pass++;
      idx++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_two_windows();
    test_zero_stream();
    test_valid_gaps();
    test_reset_and_clr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LENGTH, default 16, the LFSR register width in bits.
REQ-002 SHALL have parameter TAPS, default 53256, the feedback tap mask; bit i set means register bit i feeds the XOR.
REQ-003 SHALL have parameter LOCK_CNT, default 32, the consecutive matches required to declare lock.
REQ-004 SHALL have parameter WINDOW, default 64, the loss-of-lock observation window in valid bits.
REQ-005 SHALL have parameter LOSS_THR, default 8, the errors within one window that force loss of lock.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port din, input, 1 bit, the received serial PRBS bit.
REQ-009 SHALL have port din_valid, input, 1 bit, which qualifies din; no state advances while it is low.
REQ-010 SHALL have port clr, input, 1 bit, a synchronous clear of err_count and bit_count only.
REQ-011 SHALL have port locked, output, 1 bit, high in state LOCKED.
REQ-012 SHALL have port err_pulse, output, 1 bit, a one-cycle pulse per mismatched bit while LOCKED.
REQ-013 SHALL have port err_count, output, 32 bits, saturating count of errors detected while LOCKED.
REQ-014 SHALL have port bit_count, output, 32 bits, saturating count of valid bits checked while LOCKED.

Function
REQ-015 Stream model: the transmitter emits fb = ^(s & TAPS) each bit and shifts s <= {s[LENGTH-2:0], fb}; the checker SHALL use the same shift direction and the same feedback.
REQ-016 The checker SHALL hold a LENGTH-bit register r; the predicted bit SHALL be p = ^(r & TAPS).
REQ-017 SHALL implement states FILL, VERIFY and LOCKED, with FILL entered on reset.
REQ-018 In FILL, each valid bit SHALL give r <= {r[LENGTH-2:0], din}, and the fill counter SHALL increment.
REQ-019 After the LENGTH-th valid bit in FILL, the next state SHALL be VERIFY.
REQ-020 In VERIFY, each valid bit SHALL shift din into r.
REQ-021 In VERIFY, din == p SHALL increment the match counter, and a mismatch SHALL zero it.
REQ-022 In VERIFY, the match counter SHALL be held at 0 whenever r == 0, so an all-zero stream never locks.
REQ-023 When the match counter reaches LOCK_CNT, the checker SHALL enter LOCKED on that same edge.
REQ-024 In LOCKED, the checker SHALL flywheel: r <= {r[LENGTH-2:0], p}, so received errors do not corrupt prediction.
REQ-025 In LOCKED, each valid bit SHALL increment bit_count.
REQ-026 In LOCKED, din != p SHALL assert err_pulse for exactly the one cycle after that edge and increment err_count.
REQ-027 err_count and bit_count SHALL saturate at 2^32-1 and never wrap.
REQ-028 Loss window: a window counter SHALL count valid bits in LOCKED and a window error counter SHALL count errors.
REQ-029 When the window error count reaches LOSS_THR, the checker SHALL enter FILL on that edge, and the fill, match and window counters SHALL be cleared.
REQ-030 The checker SHALL not clear err_count or bit_count on loss of lock.
REQ-031 When the window bit count reaches WINDOW without loss, both window counters SHALL restart at 0.
REQ-032 An error landing on the final bit of a window SHALL be counted in that window before the restart.
REQ-033 din_valid low SHALL freeze r, all counters and the state, and SHALL hold err_pulse at 0.
REQ-034 If clr and an error occur in the same cycle, err_count SHALL become 0; clr SHALL take priority.
REQ-035 clr SHALL not affect the state, r or the window counters.
REQ-036 locked SHALL be a registered output equal to (state == LOCKED).

Reset
REQ-037 While rst is low, the checker SHALL asynchronously set state=FILL, r=0, all counters=0, locked=0, err_pulse=0, err_count=0 and bit_count=0.
REQ-038 Reset asserted in any state, including mid-LOCKED, SHALL take effect immediately.
REQ-039 After rst deasserts, the checker SHALL restart from FILL on the next valid bit.

Verification
REQ-040 Reference Fibonacci generator, LENGTH=16, TAPS=53256, seed 1, din_valid=1 -> locked rises after the 48th valid bit (16 fill + 32 match); err_count stays 0; bit_count = N-48 after N bits.
REQ-041 After lock, invert one bit -> exactly one err_pulse, err_count=1, locked stays 1, and the following bits produce no errors (flywheel).
REQ-042 After lock, invert 8 bits within one 64-bit window -> locked falls on the 8th error edge; relock 48 valid bits later; err_count=8 is retained.
REQ-043 Invert 7 bits in window k and 7 bits in window k+1 -> no loss of lock; err_count=14.
REQ-044 All-zero din for 1000 bits -> locked never asserts; random din_valid gaps on a good stream -> same lock bit index as REQ-040.
REQ-045 Reset asserted mid-LOCKED -> all outputs 0 immediately; after release, relock at 48 valid bits; clr pulsed while an error is injected -> err_count=0.
